// File: rtl/add_num_rd_engine_if.sv
// Bus bundle for the add-numbers read engine: CCI-P c0 request/response
// channel plus the operand stream towards the adder/write stage.
interface add_num_rd_engine_if #(
    parameter int ADDR_W = 42
);
    logic              c0_req_valid;
    logic [ADDR_W-1:0] c0_req_addr;
    logic [15:0]       c0_req_mdata;
    logic              c0TxAlmFull;
    logic              c0_rsp_valid;
    logic [15:0]       c0_rsp_mdata;
    logic [511:0]      c0_rsp_data;
    logic              op_valid;
    logic              op_ready;
    logic [7:0]        op_a;
    logic [7:0]        op_b;
    logic [15:0]       op_idx;

    modport master (
        output c0_req_valid, c0_req_addr, c0_req_mdata,
        input  c0TxAlmFull, c0_rsp_valid, c0_rsp_mdata, c0_rsp_data,
        output op_valid, op_a, op_b, op_idx,
        input  op_ready
    );

    modport slave (
        input  c0_req_valid, c0_req_addr, c0_req_mdata,
        output c0TxAlmFull, c0_rsp_valid, c0_rsp_mdata, c0_rsp_data,
        input  op_valid, op_a, op_b, op_idx,
        output op_ready
    );
endinterface

// File: rtl/add_num_rd_engine.sv
// Read engine: issues credit-limited single-line c0 reads, captures the two
// operand bytes of each response into a show-ahead FIFO, streams them out.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; latches base address and line count
// S_ISSUE | issuing read requests until all lines have been requested
// S_DRAIN | all requests issued; waiting for every operand pair to be taken
// S_DONE  | one-cycle done pulse, then back to idle
module add_num_rd_engine #(
    parameter int MAX_OUTSTANDING = 8,
    parameter int FIFO_DEPTH      = 8,
    parameter int ADDR_W          = 42
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       num_lines,
    output logic              busy,
    output logic              done,
    add_num_rd_engine_if.master bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_base;
    logic [15:0]       r_num;
    logic [15:0]       r_issued;
    logic [15:0]       r_consumed;
    logic [OUT_W-1:0]  r_outstanding;
    logic              r_req_valid;
    logic [ADDR_W-1:0] r_req_addr;
    logic [15:0]       r_req_mdata;
    logic [31:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_idle_start;
    logic              w_active;
    logic              w_issue_ok;
    logic              w_issue;
    logic [15:0]       w_issue_idx;
    logic [ADDR_W-1:0] w_issue_base;
    logic              w_push;
    logic              w_pop;
    logic [15:0]       w_consumed_nxt;
    logic [31:0]       w_head;
    logic              w_unused_rsp;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == FIFO_DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_idle_start = (r_state == S_IDLE) && start;
    assign w_active     = (r_state == S_ISSUE) || (r_state == S_DRAIN);

    // Credits cover both in-flight reads and parked FIFO entries, so every
    // response always has a FIFO slot waiting for it.
    assign w_issue_ok = !bus.c0TxAlmFull
                     && (r_issued < r_num)
                     && (32'(r_outstanding) < MAX_OUTSTANDING)
                     && (32'(r_outstanding) + 32'(r_count) < FIFO_DEPTH);

    // The first request is launched straight from IDLE to reach the bus the
    // cycle after start.
    assign w_issue = ((r_state == S_ISSUE) && w_issue_ok)
                  || (w_idle_start && (num_lines != 16'd0) && !bus.c0TxAlmFull);

    assign w_issue_idx    = (r_state == S_IDLE) ? 16'd0 : r_issued;
    assign w_issue_base   = (r_state == S_IDLE) ? base_addr : r_base;
    assign w_push         = bus.c0_rsp_valid && w_active;
    assign w_pop          = (r_count != '0) && bus.op_ready;
    assign w_consumed_nxt = r_consumed + 16'(w_pop);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = (num_lines == 16'd0) ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                if (r_issued == r_num) w_state_nxt = (w_consumed_nxt == r_num) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                if (w_consumed_nxt == r_num) w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_base        <= '0;
            r_num         <= '0;
            r_issued      <= '0;
            r_consumed    <= '0;
            r_outstanding <= '0;
            r_req_valid   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_valid <= w_issue;
            if (w_idle_start) begin
                r_base     <= base_addr;
                r_num      <= num_lines;
                r_consumed <= '0;
            end else if (w_pop) begin
                r_consumed <= w_consumed_nxt;
            end
            if (w_issue) r_issued <= w_issue_idx + 16'd1;
            else if (w_idle_start) r_issued <= '0;
            case ({w_issue, w_push})
                2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {bus.c0_rsp_data[15:8], bus.c0_rsp_data[23:16], bus.c0_rsp_mdata};
        if (w_issue) begin
            r_req_addr  <= w_issue_base + ADDR_W'(w_issue_idx);
            r_req_mdata <= w_issue_idx;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(w_push && !w_pop && (r_count == CNT_W'(FIFO_DEPTH))));

    assign w_head       = r_mem[r_rd_ptr];
    assign w_unused_rsp = ^{bus.c0_rsp_data[511:24], bus.c0_rsp_data[7:0]};

    assign busy             = (r_state != S_IDLE);
    assign done             = (r_state == S_DONE);
    assign bus.c0_req_valid = r_req_valid;
    assign bus.c0_req_addr  = r_req_addr;
    assign bus.c0_req_mdata = r_req_mdata;
    assign bus.op_valid     = (r_count != '0);
    assign bus.op_a         = w_head[31:24];
    assign bus.op_b         = w_head[23:16];
    assign bus.op_idx       = w_head[15:0];

endmodule

// File: tb/tb_add_num_rd_engine.sv
// Bench for add_num_rd_engine: directed jobs driven against an event-level
// scoreboard of requests, credits, operand order and the done pulse.
module tb_add_num_rd_engine;

    localparam int ADDR_W = 42;
    localparam int CREDITS = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [15:0]       num_lines = '0;
    logic              busy;
    logic              done;

    add_num_rd_engine_if #(.ADDR_W(ADDR_W)) bus ();

    add_num_rd_engine #(
        .MAX_OUTSTANDING(CREDITS),
        .FIFO_DEPTH(CREDITS),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .base_addr(base_addr),
        .num_lines(num_lines),
        .busy(busy),
        .done(done),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // observation logs
    logic [ADDR_W-1:0] req_addr_q[$];
    int req_idx_q[$], req_cyc_q[$];
    int pop_a_q[$], pop_b_q[$], pop_idx_q[$], pop_cyc_q[$];
    int done_cyc_q[$];
    int busy_cnt, ov_cnt, rsp_ptr;

    // scoreboard model
    logic [ADDR_W-1:0] m_base;
    int m_num, m_next, m_out, m_consumed;
    bit m_busy, m_done_exp, m_alm_prev;
    int mq_a[$], mq_b[$], mq_idx[$];
    bit cb, cd;
    logic [ADDR_W-1:0] ea;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int a_of(input int idx); return (idx * 7 + 3) & 255; endfunction
    function automatic int b_of(input int idx); return (idx * 13 + 5) & 255; endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_req_valid", bus.c0_req_valid, 0);
            chk("rst_op_valid", bus.op_valid, 0);
            m_busy = 0; m_done_exp = 0; m_alm_prev = 0;
            m_out = 0; m_next = 0; m_consumed = 0; m_num = 0;
            mq_a.delete(); mq_b.delete(); mq_idx.delete();
        end else begin
            cb = m_busy;
            cd = m_done_exp;
            chk("busy", busy, cb);
            chk("done", done, cd);
            chk("op_valid", bus.op_valid, mq_idx.size() != 0);
            if (bus.op_valid && mq_idx.size() != 0) begin
                chk("op_a", bus.op_a, mq_a[0]);
                chk("op_b", bus.op_b, mq_b[0]);
                chk("op_idx", bus.op_idx, mq_idx[0]);
            end
            if (bus.c0_req_valid) begin
                ea = m_base + ADDR_W'(m_next);
                chk("req_in_job", cb && !cd, 1);
                chk("req_mdata", bus.c0_req_mdata, m_next);
                chk("req_addr", bus.c0_req_addr, ea);
                chk("req_below_num", m_next < m_num, 1);
                chk("req_after_almfull", m_alm_prev, 0);
                m_next++;
                m_out++;
                chk("credit", (m_out <= CREDITS) && (m_out + mq_idx.size() <= CREDITS), 1);
                req_addr_q.push_back(bus.c0_req_addr);
                req_idx_q.push_back(int'(bus.c0_req_mdata));
                req_cyc_q.push_back(cyc);
            end
            if (bus.c0_rsp_valid && cb && !cd) begin
                mq_a.push_back(int'(bus.c0_rsp_data[15:8]));
                mq_b.push_back(int'(bus.c0_rsp_data[23:16]));
                mq_idx.push_back(int'(bus.c0_rsp_mdata));
                m_out--;
            end
            if (cd) begin
                m_busy = 0;
                m_done_exp = 0;
                done_cyc_q.push_back(cyc);
            end
            if (bus.op_valid && bus.op_ready) begin
                pop_a_q.push_back(int'(bus.op_a));
                pop_b_q.push_back(int'(bus.op_b));
                pop_idx_q.push_back(int'(bus.op_idx));
                pop_cyc_q.push_back(cyc);
                if (mq_idx.size() != 0) begin
                    void'(mq_a.pop_front()); void'(mq_b.pop_front()); void'(mq_idx.pop_front());
                end
                m_consumed++;
                if (m_consumed == m_num) m_done_exp = 1;
            end
            if (busy) busy_cnt++;
            if (bus.op_valid) ov_cnt++;
            if (!cb && start) begin
                m_busy = 1;
                m_base = base_addr;
                m_num = int'(num_lines);
                m_next = 0; m_consumed = 0; m_out = 0;
                if (num_lines == 16'd0) m_done_exp = 1;
            end
            m_alm_prev = bus.c0TxAlmFull;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        req_addr_q.delete(); req_idx_q.delete(); req_cyc_q.delete();
        pop_a_q.delete(); pop_b_q.delete(); pop_idx_q.delete(); pop_cyc_q.delete();
        done_cyc_q.delete();
        busy_cnt = 0; ov_cnt = 0; rsp_ptr = 0;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [15:0] n, output int ts);
        ts = cyc;
        start = 1'b1; base_addr = b; num_lines = n;
        tick();
        start = 1'b0;
    endtask

    task automatic send_rsp(input int idx, input int a, input int b);
        logic [511:0] d;
        d = {16{$urandom()}};
        d[15:8] = a[7:0];
        d[23:16] = b[7:0];
        bus.c0_rsp_valid = 1'b1;
        bus.c0_rsp_mdata = idx[15:0];
        bus.c0_rsp_data = d;
        tick();
        bus.c0_rsp_valid = 1'b0;
    endtask

    task automatic run_to_done(input string name, input int budget);
        int n;
        n = 0;
        while (done_cyc_q.size() == 0 && n < budget) begin
            if (rsp_ptr < req_idx_q.size()) begin
                send_rsp(req_idx_q[rsp_ptr], a_of(req_idx_q[rsp_ptr]), b_of(req_idx_q[rsp_ptr]));
                rsp_ptr++;
            end else begin
                tick();
            end
            n++;
        end
        chk({name, "_done_seen"}, done_cyc_q.size(), 1);
        repeat (3) tick();
        chk({name, "_done_once"}, done_cyc_q.size(), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ts, n, win;
        logic [ADDR_W-1:0] wrap_exp [4];
        bus.c0TxAlmFull = 1'b0;
        bus.c0_rsp_valid = 1'b0;
        bus.c0_rsp_mdata = '0;
        bus.c0_rsp_data = '0;
        bus.op_ready = 1'b0;
        clear_logs();
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // single line
        clear_logs();
        bus.op_ready = 1'b1;
        do_start(42'h100, 16'd1, ts);
        tick();
        chk("t1_nreq", req_idx_q.size(), 1);
        chk("t1_addr", req_addr_q[0], 42'h100);
        chk("t1_mdata", req_idx_q[0], 0);
        chk("t1_req_cycle", req_cyc_q[0], ts + 1);
        send_rsp(0, 3, 5);
        rsp_ptr = 1;
        run_to_done("t1", 50);
        chk("t1_op_a", pop_a_q[0], 3);
        chk("t1_op_b", pop_b_q[0], 5);
        chk("t1_op_idx", pop_idx_q[0], 0);
        chk("t1_done_after_pop", done_cyc_q[0], pop_cyc_q[0] + 1);

        // zero lines
        clear_logs();
        do_start(42'h0, 16'd0, ts);
        repeat (4) tick();
        chk("t2_nreq", req_idx_q.size(), 0);
        chk("t2_done_count", done_cyc_q.size(), 1);
        chk("t2_done_cycle", done_cyc_q[0], ts + 1);
        chk("t2_busy_cycles", busy_cnt, 1);

        // credit limit
        clear_logs();
        bus.op_ready = 1'b1;
        do_start(42'h2000, 16'd20, ts);
        repeat (15) tick();
        chk("t3_nreq_stalled", req_idx_q.size(), 8);
        chk("t3_last_mdata", req_idx_q[7], 7);
        run_to_done("t3", 300);
        chk("t3_npop", pop_idx_q.size(), 20);
        for (int i = 0; i < 20; i++) chk("t3_pop_order", pop_idx_q[i], i);

        // almost-full backpressure during issue cycles 2..6
        clear_logs();
        do_start(42'h5000, 16'd6, ts);
        tick();
        bus.c0TxAlmFull = 1'b1;
        repeat (5) tick();
        bus.c0TxAlmFull = 1'b0;
        repeat (8) tick();
        win = 0;
        foreach (req_cyc_q[i]) if (req_cyc_q[i] >= ts + 3 && req_cyc_q[i] <= ts + 7) win++;
        chk("t4_no_req_in_stall", win, 0);
        chk("t4_nreq", req_idx_q.size(), 6);
        chk("t4_idx1_cycle", req_cyc_q[1], ts + 2);
        chk("t4_idx2_cycle", req_cyc_q[2], ts + 8);
        run_to_done("t4", 100);

        // out-of-order responses with a stalling consumer; start while busy ignored
        clear_logs();
        bus.op_ready = 1'b0;
        do_start(42'h40, 16'd3, ts);
        repeat (4) tick();
        chk("t5_nreq", req_idx_q.size(), 3);
        start = 1'b1; base_addr = 42'h0; num_lines = 16'd9;
        tick();
        start = 1'b0;
        send_rsp(2, 8'h22, 8'h23);
        send_rsp(0, 8'h11, 8'h12);
        send_rsp(1, 8'h33, 8'h34);
        rsp_ptr = 3;
        repeat (3) tick();
        chk("t5_stalled_idx", bus.op_idx, 2);
        n = 0;
        while (done_cyc_q.size() == 0 && n < 40) begin
            bus.op_ready = ~bus.op_ready;
            tick();
            n++;
        end
        bus.op_ready = 1'b1;
        chk("t5_done_seen", done_cyc_q.size(), 1);
        chk("t5_npop", pop_idx_q.size(), 3);
        chk("t5_idx0", pop_idx_q[0], 2);
        chk("t5_idx1", pop_idx_q[1], 0);
        chk("t5_idx2", pop_idx_q[2], 1);
        chk("t5_a0", pop_a_q[0], 8'h22);
        chk("t5_b2", pop_b_q[2], 8'h34);

        // address wrap at the top of the line address space
        clear_logs();
        wrap_exp[0] = 42'h3FF_FFFF_FFFE;
        wrap_exp[1] = 42'h3FF_FFFF_FFFF;
        wrap_exp[2] = 42'h0;
        wrap_exp[3] = 42'h1;
        do_start(42'h3FF_FFFF_FFFE, 16'd4, ts);
        run_to_done("t6", 100);
        chk("t6_nreq", req_addr_q.size(), 4);
        for (int i = 0; i < 4; i++) chk("t6_wrap_addr", req_addr_q[i], wrap_exp[i]);

        // reset mid-drain, then a late response
        clear_logs();
        bus.op_ready = 1'b0;
        do_start(42'h800, 16'd2, ts);
        repeat (3) tick();
        send_rsp(0, 8'h44, 8'h45);
        rsp_ptr = 1;
        chk("t7_pre_op_valid", bus.op_valid, 1);
        chk("t7_pre_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_op_valid", bus.op_valid, 0);
        chk("t7_rst_req_valid", bus.c0_req_valid, 0);
        tick();
        reset_n = 1'b1;
        clear_logs();
        bus.op_ready = 1'b1;
        send_rsp(1, 8'h55, 8'h56);
        repeat (4) tick();
        chk("t7_late_rsp_ignored", ov_cnt, 0);
        chk("t7_no_done", done_cyc_q.size(), 0);

        // normal job after reset
        clear_logs();
        do_start(42'h900, 16'd2, ts);
        run_to_done("t8", 100);
        chk("t8_npop", pop_idx_q.size(), 2);
        chk("t8_addr1", req_addr_q[1], 42'h901);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/add_num_rd_engine.md
Name: add_num_rd_engine

Overview:
- Upstream stage of the add-two-numbers AFU datapath. Given a base cache-line address and a line count, it issues single-line CCI-P c0 read requests, with credit-limited outstanding depth and almost-full backpressure.
- It captures each read response, extracts the operand bytes, and buffers them in a show-ahead FIFO.
- It presents the operands on a valid/ready stream to the adder/write stage.

Parameters:
- MAX_OUTSTANDING, 8, maximum read requests in flight (issued, response not yet received).
- FIFO_DEPTH, 8, operand FIFO entries; must be >= MAX_OUTSTANDING.
- ADDR_W, 42, cache-line address width.

Ports:
- clk  in  1  AFU clock (host channel clock).
- reset_n  in  1  reset; asynchronous assert, active-low.
- start  in  1  one-cycle request to begin a job; sampled only in IDLE.
- base_addr  in  ADDR_W  first line address; sampled with start.
- num_lines  in  16  lines to read; sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the last operand pair has been consumed.
- c0_req_valid  out  1  read request valid (registered).
- c0_req_addr  out  ADDR_W  read line address (registered).
- c0_req_mdata  out  16  request tag = line index (registered).
- c0TxAlmFull  in  1  read request channel almost full.
- c0_rsp_valid  in  1  read response valid.
- c0_rsp_mdata  in  16  response tag.
- c0_rsp_data  in  512  response line.
- op_valid  out  1  operand pair available.
- op_ready  in  1  downstream accepts the pair.
- op_a  out  8  first operand, rsp_data[15:8].
- op_b  out  8  second operand, rsp_data[23:16].
- op_idx  out  16  line index of the pair (the response mdata).

Behaviour:
- Reset (async, reset_n=0): state IDLE; busy=0, done=0, c0_req_valid=0, op_valid=0. Issue, receive and consume counters, outstanding count, and FIFO pointers all clear. Address, mdata and data registers are don't-care.
- States:
  - IDLE: accepts start, latching base_addr and num_lines.
    - num_lines=0 -> DONE.
    - Otherwise -> ISSUE.
  - ISSUE: issues requests until issued == num_lines -> DRAIN.
  - DRAIN: waits until consumed == num_lines -> DONE.
  - DONE: asserts done for exactly one cycle -> IDLE.
- busy is 1 in ISSUE, DRAIN and DONE.
- Issue rule, evaluated each ISSUE cycle:
  - Condition: c0TxAlmFull==0, issued < num_lines, outstanding < MAX_OUTSTANDING, and outstanding + fifo_count < FIFO_DEPTH.
  - When true: next cycle c0_req_valid=1, c0_req_addr = base_addr + issued (modulo 2^ADDR_W, wraps silently), c0_req_mdata = issued; issued increments.
  - When false: next cycle c0_req_valid=0.
  - c0_req_valid is never held high across a stall.
- Latency: start in cycle T (almost-full low) -> busy=1 and first c0_req_valid=1 in cycle T+1. Back-to-back requests are allowed every cycle.
- Response: when c0_rsp_valid=1 and state is ISSUE or DRAIN, the entry {data[15:8], data[23:16], mdata} is written into the FIFO and outstanding decrements.
  - op_valid rises the cycle after the response at the earliest (registered write, show-ahead read).
  - Ordering: op order equals response arrival order, not request order; op_idx identifies the line.
- Responses while IDLE or DONE are ignored and not stored.
- The credit rule guarantees the FIFO never overflows. Overflow is an assertion failure in simulation.
- Pop: op_valid && op_ready pops an entry; consumed increments. op_a, op_b and op_idx hold stable while op_valid=1 and op_ready=0.
- Simultaneous push and pop in the same cycle: both occur; fifo_count is unchanged; a full FIFO stays consistent.
- Simultaneous issue and response in the same cycle: outstanding is unchanged.
- start while busy is ignored (no relatch, no restart).
- Reset mid-operation: all state discarded immediately; no done pulse; in-flight responses arriving after reset release are ignored (state IDLE).
- Counters are 16 bits. num_lines=65535 must complete without wrap; issued and consumed compare against the latched num_lines.

Test Plan:
- Single line: start, base_addr=0x100, num_lines=1; response data[15:8]=3, data[23:16]=5.
  -> One request: addr 0x100, mdata 0, at T+1.
  -> op_a=3, op_b=5, op_idx=0.
  -> done pulse one cycle after the pop with op_ready=1.
- Zero lines: num_lines=0 -> no c0_req_valid; busy high for exactly one cycle; done pulse at T+1.
- Credit limit: num_lines=20, responses withheld -> exactly 8 requests (mdata 0..7), then c0_req_valid stays 0. Release responses -> issue resumes; all 20 pairs delivered; done asserted once.
- Backpressure: c0TxAlmFull=1 for cycles 2-6 of ISSUE -> no requests during those cycles. Resumes at the next index with no gaps or duplicates in mdata.
- Out-of-order responses and op_ready stalls: responses tagged 2,0,1 with op_ready toggling -> op_idx sequence 2,0,1; outputs stable while stalled.
- Boundary cases:
  - base_addr = 2^42-2, num_lines=4 -> addresses 2^42-2, 2^42-1, 0, 1.
  - Reset asserted mid-DRAIN -> outputs zero immediately; a late response produces no op_valid.
  - A subsequent start works normally.
